// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: plays a CSR-programmed pattern table into the LED PIO
// through an Avalon-MM master write port, one entry per dwell period.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for a CTRL write with RUN=1
// S_WRITE | one-cycle PIO write pulse of table[index], dwell counter loaded
// S_HOLD  | dwell counter running; at 0 advance, wrap (LOOP) or finish
module led_pattern_sequencer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_HOLD} state_t;

  state_t            state, state_nxt;
  logic              run, loop_en, done;
  logic [31:0]       dwell, cnt, cnt_nxt, dwell_m1;
  logic [IDX_W:0]    length, len_eff;
  logic [IDX_W-1:0]  index, index_nxt, index_step, pat_addr;
  logic [7:0]        pat_table [DEPTH];
  logic [7:0]        led_q;
  logic              pio_cs_q, pio_wn_q;
  logic              csr_wr, ctrl_wr, start, stop, seq_done;
  logic              last_step, more_steps;

  assign csr_wr  = chipselect & ~write_n;
  assign ctrl_wr = csr_wr && (address == 3'd0);
  assign start   = ctrl_wr &  writedata[0];
  assign stop    = ctrl_wr & ~writedata[0];

  assign dwell_m1   = (dwell == 32'd0) ? 32'd0 : dwell - 32'd1;
  assign len_eff    = (length == '0) ? (IDX_W+1)'(1) : length;
  assign last_step  = ({1'b0, index} + (IDX_W+1)'(1)) >= len_eff;
  assign more_steps = ~last_step | loop_en;
  assign index_step = last_step ? '0 : index + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // cnt holds the cycles left in the current step after this one, so the
  // WRITE cycle itself counts toward the dwell and pulses are DWELL apart.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    cnt_nxt   = cnt;
    seq_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          index_nxt = '0;
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_nxt = dwell_m1;
        if (dwell_m1 == 32'd0 && more_steps) begin
          index_nxt = index_step;
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt <= 32'd1) begin
          cnt_nxt = 32'd0;
          if (more_steps) begin
            index_nxt = index_step;
            state_nxt = S_WRITE;
          end else begin
            seq_done  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt - 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && stop) begin
      state_nxt = S_IDLE;
      seq_done  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= 1'b0;
      loop_en  <= 1'b0;
      done     <= 1'b0;
      dwell    <= '0;
      length   <= '0;
      pat_addr <= '0;
      index    <= '0;
      cnt      <= '0;
      led_q    <= '0;
      pio_cs_q <= 1'b0;
      pio_wn_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) pat_table[i] <= '0;
    end else begin
      index <= index_nxt;
      cnt   <= cnt_nxt;

      if (ctrl_wr) loop_en <= writedata[1];
      if (state == S_IDLE) begin
        if (ctrl_wr) run <= writedata[0];
      end else if (stop || seq_done) begin
        run <= 1'b0;
      end

      if (state == S_IDLE && start) done <= 1'b0;
      else if (seq_done)            done <= 1'b1;

      if (csr_wr) begin
        case (address)
          3'd1: dwell  <= writedata;
          3'd2: length <= (writedata > 32'(DEPTH)) ? (IDX_W+1)'(DEPTH)
                                                   : writedata[IDX_W:0];
          3'd4: pat_addr <= writedata[IDX_W-1:0];
          3'd5: begin
            pat_table[pat_addr] <= writedata[7:0];
            pat_addr            <= pat_addr + IDX_W'(1);
          end
          default: ;
        endcase
      end

      // Table is read before this edge's CSR write lands: same-entry
      // write/play in one cycle plays the old value.
      if (state_nxt == S_WRITE) begin
        pio_cs_q <= 1'b1;
        pio_wn_q <= 1'b0;
        led_q    <= pat_table[index_nxt];
      end else begin
        pio_cs_q <= 1'b0;
        pio_wn_q <= 1'b1;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0: readdata[1:0]       = {loop_en, run};
      3'd1: readdata            = dwell;
      3'd2: readdata[IDX_W:0]   = length;
      3'd3: readdata[IDX_W+1:0] = {index, done, busy};
      3'd4: readdata[IDX_W-1:0] = pat_addr;
      3'd5: readdata[7:0]       = pat_table[pat_addr];
      default: ;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign pio_address    = 2'b00;
  assign pio_chipselect = pio_cs_q;
  assign pio_write_n    = pio_wn_q;
  assign pio_writedata  = {24'b0, led_q};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed and randomized runs compared
// against a table/arithmetic reference of the expected pulse train.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        busy;

  led_pattern_sequencer #(.DEPTH(16), .IDX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int busy_cycles = 0;
  int pulse_cyc[$];
  logic [31:0] pulse_dat[$];

  logic [7:0] ref_tab [16];
  int ref_ptr   = 0;
  int ref_dwell = 0;
  int ref_len   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && pio_chipselect && !pio_write_n) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(pio_writedata);
    end
    if (busy) busy_cycles++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic set_dwell(input int d); csr_write(3'd1, 32'(d)); ref_dwell = d; endtask
  task automatic set_len(input int l);   csr_write(3'd2, 32'(l)); ref_len = l;   endtask
  task automatic set_ptr(input int p);   csr_write(3'd4, 32'(p)); ref_ptr = p % 16; endtask
  task automatic push_pat(input logic [7:0] v);
    csr_write(3'd5, {24'b0, v});
    ref_tab[ref_ptr] = v;
    ref_ptr = (ref_ptr + 1) % 16;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(posedge clk); #1; n++; end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One non-looping run; the expected train is step k at k*dwell with table[k].
  task automatic play_check(input string tag, output int bc);
    int n, d, c0;
    logic [31:0] st;
    n = (ref_len == 0) ? 1 : ((ref_len > 16) ? 16 : ref_len);
    d = (ref_dwell == 0) ? 1 : ref_dwell;
    pulse_cyc.delete(); pulse_dat.delete();
    busy_cycles = 0;
    csr_write(3'd0, 32'h1);
    c0 = cyc;
    wait_idle(n * d + 50, tag);
    repeat (3) @(posedge clk);
    #1;
    bc = busy_cycles;
    check({tag, "_npulse"}, 32'(pulse_cyc.size()), 32'(n));
    for (int k = 0; k < n && k < pulse_cyc.size(); k++) begin
      check($sformatf("%s_dat%0d", tag, k), pulse_dat[k], {24'b0, ref_tab[k]});
      check($sformatf("%s_time%0d", tag, k), 32'(pulse_cyc[k] - c0), 32'(k * d));
    end
    check({tag, "_pioaddr"}, 32'(pio_address), 32'd0);
    csr_read(3'd3, st);
    check({tag, "_status"}, st, 32'(((n - 1) << 2) | 2));
  endtask

  initial begin
    logic [31:0] rd;
    int bc, n, nstop, c0;

    for (int i = 0; i < 16; i++) ref_tab[i] = 8'h00;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pio_cs", 32'(pio_chipselect), 32'd0);
    check("rst_pio_wn", 32'(pio_write_n), 32'd1);
    check("rst_pio_wd", pio_writedata, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    csr_read(3'd3, rd); check("rst_status", rd, 32'd0);
    csr_read(3'd0, rd); check("rst_ctrl", rd, 32'd0);

    // Three-step one-shot, dwell 5
    set_ptr(0); push_pat(8'h01); push_pat(8'h02); push_pat(8'h04);
    set_len(3); set_dwell(5);
    play_check("basic", bc);

    // Looping run, stopped mid-HOLD
    pulse_cyc.delete(); pulse_dat.delete();
    csr_write(3'd0, 32'h3);
    c0 = cyc;
    n = 0;
    while (pulse_cyc.size() < 9 && n < 200) begin @(posedge clk); #1; n++; end
    check("loop_reached9", 32'(pulse_cyc.size() >= 9), 32'd1);
    csr_write(3'd0, 32'h0);
    nstop = pulse_cyc.size();
    check("stop_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("stop_npulse", 32'(pulse_cyc.size()), 32'(nstop));
    for (int k = 0; k < pulse_cyc.size(); k++) begin
      check($sformatf("loop_dat%0d", k), pulse_dat[k], {24'b0, ref_tab[k % 3]});
      check($sformatf("loop_time%0d", k), 32'(pulse_cyc[k] - c0), 32'(k * 5));
    end
    csr_read(3'd3, rd); check("stop_done", 32'(rd[1]), 32'd0);
    check("stop_led_hold", pio_writedata, {24'b0, ref_tab[(nstop - 1) % 3]});

    // DWELL=0, LENGTH=0: one pulse, busy for WRITE+HOLD
    set_ptr(0); push_pat(8'hAA); set_dwell(0); set_len(0);
    play_check("single", bc);
    check("single_busy", 32'(bc), 32'd2);

    // LENGTH beyond DEPTH clamps to a full table pass at dwell 1
    set_ptr(0);
    for (int i = 0; i < 16; i++) push_pat(8'(8'h30 + i));
    set_dwell(1); set_len(40);
    play_check("len40", bc);

    // Randomized tables and configurations
    for (int it = 0; it < 4; it++) begin
      set_ptr($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) push_pat(8'($urandom_range(0, 255)));
      set_dwell($urandom_range(0, 6));
      set_len($urandom_range(0, 24));
      play_check($sformatf("rand%0d", it), bc);
    end

    // PAT_ADDR wrap
    set_ptr(15); push_pat(8'h11); push_pat(8'h22);
    csr_read(3'd4, rd); check("wrap_ptr", rd, 32'(ref_ptr));
    set_ptr(15); csr_read(3'd5, rd); check("wrap_tab15", rd, {24'b0, ref_tab[15]});
    set_ptr(0);  csr_read(3'd5, rd); check("wrap_tab0", rd, {24'b0, ref_tab[0]});

    // Asynchronous reset during HOLD
    set_dwell(8); set_len(4);
    pulse_cyc.delete(); pulse_dat.delete();
    csr_write(3'd0, 32'h1);
    n = 0;
    while (pulse_cyc.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    address = 3'd3; chipselect = 1'b1; write_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_pio_cs", 32'(pio_chipselect), 32'd0);
    check("arst_pio_wn", 32'(pio_write_n), 32'd1);
    check("arst_status", readdata, 32'd0);
    check("arst_pio_wd", pio_writedata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1; chipselect = 1'b0;
    for (int i = 0; i < 16; i++) ref_tab[i] = 8'h00;
    ref_ptr = 0; ref_dwell = 0; ref_len = 0;
    csr_read(3'd0, rd); check("post_rst_ctrl", rd, 32'd0);
    csr_read(3'd1, rd); check("post_rst_dwell", rd, 32'(ref_dwell));
    csr_read(3'd5, rd); check("post_rst_tab0", rd, {24'b0, ref_tab[0]});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
